chick_race_tracker: RTL
=======================

// Module: chick_race_tracker
// PURPOSE
//  Parametrised game-state engine for the chicken race board. Holds every player's
//  position and tail count, rotates turns, applies tile results from the tile-compare
//  logic, detects catches (tail steal) and the game winner. Sits between tile match
//  logic (upstream) and display/FND drivers (downstream).
// PARAMETERS
//  NUM_PLAYERS  4   players on board, 2..8; PID_W = $clog2(NUM_PLAYERS) (localparam)
//  POS_W        5   position width; BOARD_LEN <= 2**POS_W
//  BOARD_LEN    24  board tiles, multiple of NUM_PLAYERS; positions 0..BOARD_LEN-1
// PORTS
//  clk          in   1                      system clock, rising edge
//  rst          in   1                      async reset, active-high
//  new_game     in   1                      sync restart to reset state (any FSM state)
//  move_valid   in   1                      tile result offered
//  move_hit     in   1                      1 = correct tile, 0 = miss; sampled with valid
//  move_ready   out  1                      high only in IDLE
//  cur_player   out  PID_W                  player whose turn it is
//  pos_bus      out  NUM_PLAYERS*POS_W      player i position at [i*POS_W +: POS_W]
//  tail_bus     out  NUM_PLAYERS*(PID_W+1)  player i tail count, same packing
//  evt_valid    out  1                      1-cycle pulse when a move finishes
//  evt_caught   out  1                      with evt_valid: catch occurred
//  win          out  1                      sticky until new_game/rst
//  winner       out  PID_W                  valid when win=1
//  move_cnt     out  16                     see CONFIGURATION
// BEHAVIOUR
//  Reset/new_game: pos[i]=i*BOARD_LEN/NUM_PLAYERS, tail[i]=1, cur_player=0, win=0,
//   winner=0, evt_*=0, move_cnt=0, state IDLE. new_game has priority over all else.
//  FSM: IDLE, ADV, CHECK, PASS, WIN.
//  IDLE: move_ready=1; accept on move_valid&move_ready -> ADV if hit, PASS if miss.
//  ADV (1 cycle): pos[cur] <= (pos[cur]+1 == BOARD_LEN) ? 0 : pos[cur]+1 (wrap) -> CHECK.
//  CHECK (1 cycle): alive player j!=cur (tail[j]>0) with pos[j]==pos[cur] is caught:
//   tail[cur] += tail[j], tail[j] = 0, evt_caught=1. At most one match (live players
//   never share a tile). If new tail[cur]==NUM_PLAYERS -> WIN, winner=cur; else IDLE
//   with same cur_player (hit keeps turn). evt_valid pulses on this transition.
//  PASS (1 cycle): cur_player <= next index after cur (mod NUM_PLAYERS) with tail>0;
//   evt_valid pulse, evt_caught=0 -> IDLE.
//  WIN: move_ready=0, all state frozen, only new_game/rst leave.
//  Latency: hit accepted edge k -> pos updated edge k+1 -> evt/tails edge k+2.
//   Miss accepted edge k -> cur_player updated with evt_valid at edge k+1.
//  Throughput: max one move per 3 cycles (hit) / 2 cycles (miss); move_valid ignored
//   outside IDLE, upstream must hold valid until ready.
//  Caught players (tail 0) are never cur_player again and never matched.
//  Reset/new_game mid-ADV/CHECK discards the in-flight move; no evt pulse.
//  Sum of all tails always == NUM_PLAYERS.
// CONFIGURATION
//  CHICK_MOVE_CNT_EN defined: move_cnt counts accepted moves (hit+miss), saturates at
//   16'hFFFF, cleared by rst/new_game, frozen in WIN.
//  Not defined: move_cnt tied to 16'h0, no counter flops.
// TESTING
//  1 rst, defaults -> pos_bus {18,12,6,0}, tails {1,1,1,1}, cur_player 0, move_ready 1.
//  2 P0 hit x5 -> pos[0]=5, cur_player 0, evt_valid 5 pulses, evt_caught 0.
//  3 P0 hit x6 -> pos[0]=6 == pos[1]: tail[0]=2, tail[1]=0, evt_caught on 6th evt.
//  4 miss from P0 after test 3 -> cur_player 2 (P1 skipped); P3 at 18 hit x6 -> pos[3]=0 (wrap).
//  5 P0 catches P1,P2,P3 in turn -> tail[0]=4, win=1, winner=0, move_ready 0;
//    further move_valid ignored; new_game -> reset state of test 1.
//  6 assert rst during CHECK of a catching move -> all outputs reset, no evt pulse;
//    with CHICK_MOVE_CNT_EN: 3 hits + 2 misses -> move_cnt=5; without: move_cnt=0.

Source files
------------

// File: rtl/chick_race_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chick_race_tracker_if                                           |
// | Purpose  : Bundles the move handshake, board state buses, event and win    |
// |            reporting of the chicken race game-state engine.               |
// | Modports : master - upstream tile logic / display side (drives new_game,   |
// |                     move_valid, move_hit; observes everything else)        |
// |            slave  - chick_race_tracker itself                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface chick_race_tracker_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int POS_W       = 5
);
  localparam int PID_W = $clog2(NUM_PLAYERS);

  logic                             new_game;
  logic                             move_valid;
  logic                             move_hit;
  logic                             move_ready;
  logic [PID_W-1:0]                 cur_player;
  logic [NUM_PLAYERS*POS_W-1:0]     pos_bus;
  logic [NUM_PLAYERS*(PID_W+1)-1:0] tail_bus;
  logic                             evt_valid;
  logic                             evt_caught;
  logic                             win;
  logic [PID_W-1:0]                 winner;
  logic [15:0]                      move_cnt;

  modport master (
    output new_game, move_valid, move_hit,
    input  move_ready, cur_player, pos_bus, tail_bus,
           evt_valid, evt_caught, win, winner, move_cnt
  );

  modport slave (
    input  new_game, move_valid, move_hit,
    output move_ready, cur_player, pos_bus, tail_bus,
           evt_valid, evt_caught, win, winner, move_cnt
  );
endinterface
`default_nettype wire

// File: rtl/chick_race_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chick_race_tracker                                              |
// | Purpose  : Game-state engine for the chicken race board. Keeps positions   |
// |            and tail counts of all players, rotates turns, applies tile     |
// |            results, detects tail steals and the game winner.               |
// | Ports    : clk  - rising-edge clock                                        |
// |            rst  - asynchronous active-high reset                           |
// |            bus  - chick_race_tracker_if.slave: new_game, move_valid,       |
// |                   move_hit in; move_ready, cur_player, pos_bus, tail_bus,  |
// |                   evt_valid, evt_caught, win, winner, move_cnt out         |
// | Options  : CHICK_MOVE_CNT_EN - when defined, move_cnt counts accepted      |
// |            moves (saturating); otherwise move_cnt is constant zero.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module chick_race_tracker #(
  parameter int NUM_PLAYERS = 4,
  parameter int POS_W       = 5,
  parameter int BOARD_LEN   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  chick_race_tracker_if.slave  bus
);
  localparam int PID_W  = $clog2(NUM_PLAYERS);
  localparam int TAIL_W = PID_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADV   = 3'd1,
    S_CHECK = 3'd2,
    S_PASS  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [POS_W-1:0]  r_pos  [NUM_PLAYERS];
  logic [TAIL_W-1:0] r_tail [NUM_PLAYERS];
  logic [PID_W-1:0]  r_cur, r_winner;
  logic              r_win, r_evt_valid, r_evt_caught;

  logic              w_accept;
  logic [POS_W-1:0]  w_adv_pos;
  logic              w_catch;
  logic [PID_W-1:0]  w_catch_idx;
  logic [TAIL_W-1:0] w_new_tail;
  logic              w_win_now;
  logic [PID_W-1:0]  w_next, w_cand;
  logic              w_found;

  // new_game outranks a pending move, so it also blocks acceptance.
  assign w_accept  = (r_state == S_IDLE) && bus.move_valid && !bus.new_game;
  assign w_adv_pos = (r_pos[r_cur] == POS_W'(BOARD_LEN - 1)) ? '0 : r_pos[r_cur] + POS_W'(1);

  // Live players never share a tile, so at most one j can match.
  always_comb begin
    w_catch     = 1'b0;
    w_catch_idx = '0;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (PID_W'(j) != r_cur && r_tail[j] != '0 && r_pos[j] == r_pos[r_cur]) begin
        w_catch     = 1'b1;
        w_catch_idx = PID_W'(j);
      end
    end
  end

  assign w_new_tail = w_catch ? r_tail[r_cur] + r_tail[w_catch_idx] : r_tail[r_cur];
  assign w_win_now  = (w_new_tail == TAIL_W'(NUM_PLAYERS));

  // First player after cur (wrapping) that still owns a tail.
  always_comb begin
    w_next  = r_cur;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k < NUM_PLAYERS; k++) begin
      w_cand = PID_W'((int'(r_cur) + k) % NUM_PLAYERS);
      if (!w_found && r_tail[w_cand] != '0) begin
        w_found = 1'b1;
        w_next  = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.new_game) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = bus.move_hit ? S_ADV : S_PASS;
        S_ADV:   w_state_nxt = S_CHECK;
        S_CHECK: w_state_nxt = w_win_now ? S_WIN : S_IDLE;
        S_PASS:  w_state_nxt = S_IDLE;
        S_WIN:   w_state_nxt = S_WIN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_pos[i]  <= POS_W'(i * BOARD_LEN / NUM_PLAYERS);
        r_tail[i] <= TAIL_W'(1);
      end
      r_cur        <= '0;
      r_win        <= 1'b0;
      r_winner     <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_caught <= 1'b0;
    end else if (bus.new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_pos[i]  <= POS_W'(i * BOARD_LEN / NUM_PLAYERS);
        r_tail[i] <= TAIL_W'(1);
      end
      r_cur        <= '0;
      r_win        <= 1'b0;
      r_winner     <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_caught <= 1'b0;
    end else begin
      r_evt_valid  <= 1'b0;
      r_evt_caught <= 1'b0;
      case (r_state)
        S_ADV: r_pos[r_cur] <= w_adv_pos;
        S_CHECK: begin
          r_tail[r_cur] <= w_new_tail;
          if (w_catch) r_tail[w_catch_idx] <= '0;
          r_evt_valid  <= 1'b1;
          r_evt_caught <= w_catch;
          if (w_win_now) begin
            r_win    <= 1'b1;
            r_winner <= r_cur;
          end
        end
        S_PASS: begin
          r_cur       <= w_next;
          r_evt_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CHICK_MOVE_CNT_EN
  logic [15:0] r_move_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_move_cnt <= '0;
    else if (bus.new_game)                        r_move_cnt <= '0;
    else if (w_accept && r_move_cnt != 16'hFFFF)  r_move_cnt <= r_move_cnt + 16'd1;
  end
  assign bus.move_cnt = r_move_cnt;
`else
  assign bus.move_cnt = 16'h0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pack
      assign bus.pos_bus[gi*POS_W +: POS_W]    = r_pos[gi];
      assign bus.tail_bus[gi*TAIL_W +: TAIL_W] = r_tail[gi];
    end
  endgenerate

  assign bus.move_ready = (r_state == S_IDLE);
  assign bus.cur_player = r_cur;
  assign bus.evt_valid  = r_evt_valid;
  assign bus.evt_caught = r_evt_caught;
  assign bus.win        = r_win;
  assign bus.winner     = r_winner;
endmodule
`default_nettype wire
